// File: rtl/iommu_pkg.sv
// Shared IOMMU types for the fault-queue writer: record layout, fqcsr view and FSM states.
package iommu_pkg;

    localparam int unsigned FQ_PLEN       = 56;
    localparam int unsigned FQ_LOG2SZ_MAX = 15;
    localparam int unsigned FQ_REC_BYTES  = 32;
    localparam int unsigned FQ_REC_BITS   = FQ_REC_BYTES * 8;
    localparam int unsigned FQ_PPN_W      = 44;
    localparam int unsigned FQ_IDX_W      = 32;
    localparam int unsigned FQ_DW_W       = 64;

    // Record as four doublewords; dw0 occupies bits [63:0] and is written first.
    typedef struct packed {
        logic [FQ_DW_W-1:0] dw3;
        logic [FQ_DW_W-1:0] dw2;
        logic [FQ_DW_W-1:0] dw1;
        logic [FQ_DW_W-1:0] dw0;
    } fq_record_t;

    typedef struct packed {
        logic busy;
        logic fqon;
        logic fqof;
        logic fqmf;
        logic fie;
        logic fqen;
    } fqcsr_t;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_REQ  = 2'd1,
        FQ_RESP = 2'd2
    } fq_wr_state_e;

endpackage

// File: rtl/iommu_fq_writer.sv
// Fault-queue producer: accepts one fault record, writes it as four 64-bit
// beats to the in-memory queue at fqb + fqt*32, then advances fqt and raises fip.
module iommu_fq_writer
    import iommu_pkg::*;
#(
    parameter int unsigned PLEN       = FQ_PLEN,
    parameter int unsigned LOG2SZ_MAX = FQ_LOG2SZ_MAX
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rec_valid_i,
    output logic                rec_ready_o,
    input  fq_record_t          rec_i,
    input  logic [FQ_PPN_W-1:0] fqb_ppn_i,
    input  logic [4:0]          fqb_log2szm1_i,
    input  logic [FQ_IDX_W-1:0] fqh_i,
    input  logic                fqen_i,
    input  logic                fqmf_clr_i,
    input  logic                fqof_clr_i,
    input  logic                fip_clr_i,
    output logic [FQ_IDX_W-1:0] fqt_o,
    output logic                fqon_o,
    output logic                busy_o,
    output logic                fqmf_o,
    output logic                fqof_o,
    output logic                fip_o,
    output logic                mem_req_o,
    output logic [PLEN-1:0]     mem_addr_o,
    output logic [FQ_DW_W-1:0]  mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic                mem_err_i
);

    fq_wr_state_e        state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    fq_record_t          rec_q, rec_d;
    logic [FQ_IDX_W-1:0] fqt_q, fqt_d;
    logic                fqon_q, fqon_d;
    logic                fqmf_q, fqmf_d;
    logic                fqof_q, fqof_d;
    logic                fip_q, fip_d;
    logic                ready_q, busy_q, req_q;
    logic [PLEN-1:0]     addr_q, addr_d;
    logic [FQ_DW_W-1:0]  wdata_q, wdata_d;

    logic [4:0]             log2szm1;
    logic [FQ_IDX_W-1:0]    idx_mask;
    logic [FQ_IDX_W-1:0]    tail_inc;
    logic [FQ_IDX_W-1:0]    head_m;
    logic [PLEN-1:0]        fq_base;
    logic [FQ_REC_BITS-1:0] rec_vec_d;
    logic                   accept;
    logic                   load_beat;

    // Queue geometry: oversized log2szm1 is clamped, indices wrap at N entries.
    assign log2szm1 = (fqb_log2szm1_i > 5'(LOG2SZ_MAX)) ? 5'(LOG2SZ_MAX) : fqb_log2szm1_i;
    assign idx_mask = (FQ_IDX_W'(1) << (6'(log2szm1) + 6'd1)) - FQ_IDX_W'(1);
    assign tail_inc = (fqt_q + FQ_IDX_W'(1)) & idx_mask;
    assign head_m   = fqh_i & idx_mask;
    assign fq_base  = PLEN'({fqb_ppn_i, 12'h000});
    assign accept   = rec_valid_i & ready_q;
    assign rec_vec_d = rec_d;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rec_d     = rec_q;
        fqt_d     = fqt_q;
        fqon_d    = fqon_q;
        fqmf_d    = fqmf_q;
        fqof_d    = fqof_q;
        fip_d     = fip_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_beat = 1'b0;

        // Clears first so that a set later in this cycle wins.
        if (fqmf_clr_i) fqmf_d = 1'b0;
        if (fqof_clr_i) fqof_d = 1'b0;
        if (fip_clr_i)  fip_d  = 1'b0;

        unique case (state_q)
            FQ_IDLE: begin
                fqon_d = fqen_i;
                if (fqen_i && !fqon_q) begin
                    fqt_d  = '0;
                    fqmf_d = 1'b0;
                    fqof_d = 1'b0;
                end
                if (accept && fqon_q && !fqmf_q && !fqof_q) begin
                    if (tail_inc == head_m) begin
                        fqof_d = 1'b1;
                    end else begin
                        rec_d     = rec_i;
                        beat_d    = 2'd0;
                        state_d   = FQ_REQ;
                        load_beat = 1'b1;
                    end
                end
            end
            FQ_REQ: begin
                if (mem_gnt_i) state_d = FQ_RESP;
            end
            FQ_RESP: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i) begin
                        fqmf_d  = 1'b1;
                        state_d = FQ_IDLE;
                    end else if (beat_q != 2'd3) begin
                        beat_d    = beat_q + 2'd1;
                        state_d   = FQ_REQ;
                        load_beat = 1'b1;
                    end else begin
                        fqt_d   = tail_inc;
                        fip_d   = 1'b1;
                        state_d = FQ_IDLE;
                    end
                end
            end
            default: state_d = FQ_IDLE;
        endcase

        // Address/data latched once per beat so they stay stable until grant.
        if (load_beat) begin
            addr_d  = fq_base + (PLEN'(fqt_q) << 5) + (PLEN'(beat_d) << 3);
            wdata_d = rec_vec_d[{beat_d, 6'b0} +: FQ_DW_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FQ_IDLE;
            beat_q  <= '0;
            rec_q   <= '0;
            fqt_q   <= '0;
            fqon_q  <= 1'b0;
            fqmf_q  <= 1'b0;
            fqof_q  <= 1'b0;
            fip_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rec_q   <= rec_d;
            fqt_q   <= fqt_d;
            fqon_q  <= fqon_d;
            fqmf_q  <= fqmf_d;
            fqof_q  <= fqof_d;
            fip_q   <= fip_d;
            ready_q <= (state_d == FQ_IDLE);
            busy_q  <= (state_d != FQ_IDLE);
            req_q   <= (state_d == FQ_REQ);
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rec_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign fqt_o       = fqt_q;
    assign fqon_o      = fqon_q;
    assign fqmf_o      = fqmf_q;
    assign fqof_o      = fqof_q;
    assign fip_o       = fip_q;

endmodule

// File: tb/tb_iommu_fq_writer.sv
// Directed bench for iommu_fq_writer with a small reactive memory responder.
module tb_iommu_fq_writer;
    import iommu_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               rec_valid_i;
    logic               rec_ready_o;
    fq_record_t         rec_i;
    logic [43:0]        fqb_ppn_i;
    logic [4:0]         fqb_log2szm1_i;
    logic [31:0]        fqh_i;
    logic               fqen_i;
    logic               fqmf_clr_i;
    logic               fqof_clr_i;
    logic               fip_clr_i;
    logic [31:0]        fqt_o;
    logic               fqon_o;
    logic               busy_o;
    logic               fqmf_o;
    logic               fqof_o;
    logic               fip_o;
    logic               mem_req_o;
    logic [55:0]        mem_addr_o;
    logic [63:0]        mem_wdata_o;
    logic               mem_gnt_i;
    logic               mem_rvalid_i;
    logic               mem_err_i;

    iommu_fq_writer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rec_valid_i    (rec_valid_i),
        .rec_ready_o    (rec_ready_o),
        .rec_i          (rec_i),
        .fqb_ppn_i      (fqb_ppn_i),
        .fqb_log2szm1_i (fqb_log2szm1_i),
        .fqh_i          (fqh_i),
        .fqen_i         (fqen_i),
        .fqmf_clr_i     (fqmf_clr_i),
        .fqof_clr_i     (fqof_clr_i),
        .fip_clr_i      (fip_clr_i),
        .fqt_o          (fqt_o),
        .fqon_o         (fqon_o),
        .busy_o         (busy_o),
        .fqmf_o         (fqmf_o),
        .fqof_o         (fqof_o),
        .fip_o          (fip_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_err_i      (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Memory responder state
    int          gnt_delay = 0;
    int          err_at    = -1;
    int          n_wr      = 0;
    int          unstable  = 0;
    int          wcnt      = 0;
    bit          pend      = 1'b0;
    logic [55:0] hold_a;
    logic [63:0] hold_d;
    logic [55:0] wr_addr[$];
    logic [63:0] wr_data[$];

    typedef struct {
        logic [255:0] rec;
        bit           exp_wr;
        int           slot;
        logic [31:0]  exp_fqt;
        logic         exp_fqof;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_rec(input int s);
        logic [255:0] r;
        for (int k = 0; k < 4; k++)
            r[64*k +: 64] = 64'hF00D_0000_0000_0000 | (64'(s) << 8) | 64'(k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_rec(input logic [255:0] r);
        rec_i       = r;
        rec_valid_i = 1'b1;
        tick();
        rec_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm, output int busy_cyc);
        int n;
        n = 0;
        busy_cyc = 0;
        @(negedge clk_i);
        while (busy_o && n < budget) begin
            busy_cyc++;
            n++;
            @(negedge clk_i);
        end
        if (busy_o) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: busy_o still 1 after %0d cycles", nm, budget);
        end
        tick();
    endtask

    task automatic chk_writes(input int first, input int slot, input logic [255:0] r, input string nm);
        for (int k = 0; k < 4; k++) begin
            if (first + k >= wr_addr.size()) begin
                checks++;
                failures++;
                $display("FAIL %s_beat%0d: write missing, got %0d writes", nm, k, wr_addr.size());
            end else begin
                chk($sformatf("%s_addr%0d", nm, k), 64'(wr_addr[first+k]),
                    64'h8000_0000 + 64'(slot * 32 + k * 8));
                chk($sformatf("%s_data%0d", nm, k), wr_data[first+k], r[64*k +: 64]);
            end
        end
    endtask

    // Reactive memory: grant after gnt_delay cycles of request, respond the following cycle.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_err_i    = 1'b0;
            if (!rst_ni) begin
                pend = 1'b0;
                wcnt = 0;
            end else if (pend) begin
                mem_rvalid_i = 1'b1;
                mem_err_i    = ((n_wr - 1) == err_at);
                pend         = 1'b0;
            end else if (mem_req_o) begin
                if (wcnt == 0) begin
                    hold_a = mem_addr_o;
                    hold_d = mem_wdata_o;
                end else if (mem_addr_o !== hold_a || mem_wdata_o !== hold_d) begin
                    unstable++;
                end
                if (wcnt >= gnt_delay) begin
                    mem_gnt_i = 1'b1;
                    wr_addr.push_back(mem_addr_o);
                    wr_data.push_back(mem_wdata_o);
                    n_wr++;
                    pend = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        int base_n;
        int bc;
        int n;

        tbl[0] = '{rec: mk_rec(2), exp_wr: 1'b1, slot: 0, exp_fqt: 32'd1, exp_fqof: 1'b0};
        tbl[1] = '{rec: mk_rec(3), exp_wr: 1'b1, slot: 1, exp_fqt: 32'd2, exp_fqof: 1'b0};
        tbl[2] = '{rec: mk_rec(4), exp_wr: 1'b1, slot: 2, exp_fqt: 32'd3, exp_fqof: 1'b0};
        tbl[3] = '{rec: mk_rec(5), exp_wr: 1'b0, slot: 0, exp_fqt: 32'd3, exp_fqof: 1'b1};

        rst_ni         = 1'b0;
        rec_valid_i    = 1'b0;
        rec_i          = '0;
        fqb_ppn_i      = 44'h80000;
        fqb_log2szm1_i = 5'd3;
        fqh_i          = 32'd0;
        fqen_i         = 1'b1;
        fqmf_clr_i     = 1'b0;
        fqof_clr_i     = 1'b0;
        fip_clr_i      = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_fqt", 64'(fqt_o), 64'd0);
        chk("rst_ready", 64'(rec_ready_o), 64'd0);
        chk("rst_req", 64'(mem_req_o), 64'd0);
        chk("rst_fqon", 64'(fqon_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_fip", 64'(fip_o), 64'd0);
        rst_ni = 1'b1;
        tick();
        tick();
        chk("post_rst_ready", 64'(rec_ready_o), 64'd1);
        chk("post_rst_fqon", 64'(fqon_o), 64'd1);

        // Single record into a 16-entry queue
        base_n = n_wr;
        send_rec(mk_rec(1));
        wait_idle(100, "a", bc);
        chk("a_nwr", 64'(n_wr - base_n), 64'd4);
        chk_writes(base_n, 0, mk_rec(1), "a");
        chk("a_fqt", 64'(fqt_o), 64'd1);
        chk("a_fip", 64'(fip_o), 64'd1);
        chk("a_busy_cycles", 64'(bc), 64'd8);
        fip_clr_i = 1'b1;
        tick();
        fip_clr_i = 1'b0;
        chk("a_fip_clr", 64'(fip_o), 64'd0);

        // Re-enable with N=4 so the tail restarts at 0
        fqb_log2szm1_i = 5'd1;
        fqen_i = 1'b0;
        tick();
        tick();
        chk("b_fqon_off", 64'(fqon_o), 64'd0);
        fqen_i = 1'b1;
        tick();
        tick();
        chk("b_fqon_on", 64'(fqon_o), 64'd1);
        chk("b_fqt_restart", 64'(fqt_o), 64'd0);

        for (int i = 0; i < 4; i++) begin
            base_n = n_wr;
            send_rec(tbl[i].rec);
            wait_idle(100, $sformatf("tbl%0d", i), bc);
            chk($sformatf("tbl%0d_nwr", i), 64'(n_wr - base_n), tbl[i].exp_wr ? 64'd4 : 64'd0);
            if (tbl[i].exp_wr) chk_writes(base_n, tbl[i].slot, tbl[i].rec, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_fqt", i), 64'(fqt_o), 64'(tbl[i].exp_fqt));
            chk($sformatf("tbl%0d_fqof", i), 64'(fqof_o), 64'(tbl[i].exp_fqof));
        end

        // Clear overflow, move head, write last slot and wrap tail
        fqh_i      = 32'd2;
        fqof_clr_i = 1'b1;
        tick();
        fqof_clr_i = 1'b0;
        chk("wrap_fqof_clr", 64'(fqof_o), 64'd0);
        base_n = n_wr;
        send_rec(mk_rec(10));
        wait_idle(100, "wrap", bc);
        chk_writes(base_n, 3, mk_rec(10), "wrap");
        chk("wrap_fqt", 64'(fqt_o), 64'd0);

        // Memory error on beat 2
        err_at = n_wr + 2;
        base_n = n_wr;
        send_rec(mk_rec(11));
        wait_idle(100, "err", bc);
        chk("err_nwr", 64'(n_wr - base_n), 64'd3);
        chk("err_fqmf", 64'(fqmf_o), 64'd1);
        chk("err_fqt", 64'(fqt_o), 64'd0);
        err_at = -1;
        base_n = n_wr;
        send_rec(mk_rec(12));
        wait_idle(100, "err_drop", bc);
        chk("err_drop_nwr", 64'(n_wr - base_n), 64'd0);
        chk("err_drop_fqt", 64'(fqt_o), 64'd0);
        fqmf_clr_i = 1'b1;
        tick();
        fqmf_clr_i = 1'b0;
        chk("err_fqmf_clr", 64'(fqmf_o), 64'd0);
        base_n = n_wr;
        send_rec(mk_rec(13));
        wait_idle(100, "recover", bc);
        chk_writes(base_n, 0, mk_rec(13), "recover");
        chk("recover_fqt", 64'(fqt_o), 64'd1);

        // Slow grant, fqen dropped during beat 1
        fqh_i     = 32'd0;
        gnt_delay = 5;
        unstable  = 0;
        base_n    = n_wr;
        send_rec(mk_rec(14));
        n = 0;
        while (n_wr != base_n + 1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n_wr != base_n + 1) begin
            checks++;
            failures++;
            $display("FAIL slow_beat0_timeout: writes %0d expected %0d", n_wr - base_n, 1);
        end
        tick();
        fqen_i = 1'b0;
        tick();
        chk("slow_fqon_mid", 64'(fqon_o), 64'd1);
        wait_idle(300, "slow", bc);
        tick();
        chk("slow_unstable", 64'(unstable), 64'd0);
        chk_writes(base_n, 1, mk_rec(14), "slow");
        chk("slow_fqt", 64'(fqt_o), 64'd2);
        chk("slow_fqon_off", 64'(fqon_o), 64'd0);
        base_n = n_wr;
        send_rec(mk_rec(15));
        wait_idle(100, "off_drop", bc);
        chk("off_drop_nwr", 64'(n_wr - base_n), 64'd0);
        chk("off_drop_fqt", 64'(fqt_o), 64'd2);

        // fip clear coinciding with the final response
        gnt_delay = 0;
        fqen_i    = 1'b1;
        tick();
        tick();
        chk("fip_fqt_restart", 64'(fqt_o), 64'd0);
        fip_clr_i = 1'b1;
        tick();
        fip_clr_i = 1'b0;
        chk("fip_pre_clr", 64'(fip_o), 64'd0);
        send_rec(mk_rec(16));
        repeat (7) tick();
        fip_clr_i = 1'b1;
        tick();
        fip_clr_i = 1'b0;
        chk("fip_set_wins", 64'(fip_o), 64'd1);
        chk("fip_fqt", 64'(fqt_o), 64'd1);
        chk("fip_busy_done", 64'(busy_o), 64'd0);

        // Async reset while a request is outstanding
        gnt_delay = 5;
        base_n    = n_wr;
        send_rec(mk_rec(17));
        @(negedge clk_i);
        chk("arst_req_before", 64'(mem_req_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 64'(mem_req_o), 64'd0);
        chk("arst_fqt", 64'(fqt_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_fip", 64'(fip_o), 64'd0);
        gnt_delay = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        chk("arst_ready", 64'(rec_ready_o), 64'd1);
        chk("arst_nwr", 64'(n_wr - base_n), 64'd0);
        chk("arst_fqt_after", 64'(fqt_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
